// File: rtl/musa_pkg.sv
// musa_pkg: shared definitions for the EX/MEM boundary.
//   - condition flag codes produced by the alu and held in the flag register
//   - bit positions inside the 4-bit control bundle {reg_write, mem_read, mem_write, mem_to_reg}
//   - state encoding for the EX/MEM pipeline register FSM
package musa_pkg;

    // Condition flag codes
    localparam logic [2:0] FLAG_NONE      = 3'd0;
    localparam logic [2:0] FLAG_EQUAL     = 3'd1;
    localparam logic [2:0] FLAG_EXCEPTION = 3'd2;
    localparam logic [2:0] FLAG_OVERFLOW  = 3'd3;
    localparam logic [2:0] FLAG_UNDERFLOW = 3'd4;
    localparam logic [2:0] FLAG_ABOVE     = 3'd5;

    // Control bundle bit indices
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    // EX/MEM register FSM: FLUSH_PEND remembers a flush that arrived while MEM stalled
    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_PEND = 1'b1
    } ex_mem_state_e;

endpackage

// File: rtl/flag_reg.sv
// flag_reg: architectural condition flag register.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset, clears q
//   we    - write enable (qualified by the caller)
//   d     - next flag value
//   q     - stored flag value
module flag_reg #(
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [FLAG_W-1:0] d,
    output logic [FLAG_W-1:0] q
);

    logic [FLAG_W-1:0] flag_r;

    // Flag storage: load on qualified write, otherwise hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_r <= {FLAG_W{1'b0}};
        end else if (we) begin
            flag_r <= d;
        end
    end

    assign q = flag_r;

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX -> MEM pipeline register.
// Captures result, store data, destination and control from EX with one cycle
// latency, honours MEM back-pressure (mem_stall), turns flushed or wrong-path
// instructions into bubbles, remembers a flush that arrives during a stall
// (FLUSH_PEND), owns the architectural flag register and issues a one-cycle
// branch redirect to fetch.
// Ports:
//   clk, reset (async active-low)
//   ex_*            - instruction fields from EX
//   mem_stall       - MEM busy, hold contents
//   flush           - kill the instruction entering from EX
//   ex_ready        - register accepts this cycle
//   mem_*           - registered fields to MEM (mem_ctrl is 0 whenever mem_valid is 0)
//   flag_q          - flag register, feeds alu BRFL
//   redirect        - one-cycle taken-branch pulse; redirect_pc is its target
// Optional build macro EX_MEM_FWD_EN adds fwd_valid/fwd_dest/fwd_data for
// EX operand bypass from this stage.
module ex_mem_reg
    import musa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [FLAG_W-1:0] ex_flag,
    input  logic              ex_flag_we,
    input  logic              ex_branch,
    input  logic              ex_is_branch,
    input  logic [DATA_W-1:0] ex_target,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [3:0]        ex_ctrl,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              ex_ready,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_dest,
    output logic [3:0]        mem_ctrl,
    output logic [FLAG_W-1:0] flag_q,
    output logic              redirect,
`ifdef EX_MEM_FWD_EN
    output logic [DATA_W-1:0] redirect_pc,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data
`else
    output logic [DATA_W-1:0] redirect_pc
`endif
);

    ex_mem_state_e     state_r;
    ex_mem_state_e     state_nxt_s;
    logic              kill_r;
    logic              accept_s;
    logic              bubble_s;
    logic              take_s;
    logic              br_take_s;
    logic              flag_we_s;

    logic              mem_valid_r;
    logic [DATA_W-1:0] mem_result_r;
    logic [DATA_W-1:0] mem_store_data_r;
    logic [REG_AW-1:0] mem_dest_r;
    logic [3:0]        mem_ctrl_r;
    logic              redirect_r;
    logic [DATA_W-1:0] redirect_pc_r;

    assign accept_s = ~mem_stall;

    // Accept qualification and FSM next state
    always_comb begin
        state_nxt_s = state_r;
        // A pending flush, a fresh flush or the wrong-path slot after a redirect
        // all enter MEM as a bubble.
        bubble_s    = (state_r == FLUSH_PEND) | flush | kill_r;
        take_s      = accept_s & ~bubble_s & ex_valid;
        br_take_s   = take_s & ex_is_branch & ex_branch;
        flag_we_s   = take_s & ex_flag_we;
        case (state_r)
            RUN: begin
                if (mem_stall && flush) begin
                    state_nxt_s = FLUSH_PEND;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH_PEND: begin
                if (!mem_stall) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = FLUSH_PEND;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pipeline payload: load, bubble (data held) or hold under stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid_r      <= 1'b0;
            mem_result_r     <= {DATA_W{1'b0}};
            mem_store_data_r <= {DATA_W{1'b0}};
            mem_dest_r       <= {REG_AW{1'b0}};
            mem_ctrl_r       <= 4'b0000;
        end else if (accept_s) begin
            if (bubble_s) begin
                mem_valid_r <= 1'b0;
                mem_ctrl_r  <= 4'b0000;
            end else begin
                mem_valid_r      <= ex_valid;
                mem_result_r     <= ex_result;
                mem_store_data_r <= ex_store_data;
                mem_dest_r       <= ex_dest;
                mem_ctrl_r       <= ex_valid ? ex_ctrl : 4'b0000;
            end
        end
    end

    // Redirect pulse and wrong-path kill; redirect drops on the next cycle even
    // under stall because only an accepted branch can raise it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= {DATA_W{1'b0}};
            kill_r        <= 1'b0;
        end else begin
            redirect_r <= br_take_s;
            if (br_take_s) begin
                redirect_pc_r <= ex_target;
                kill_r        <= 1'b1;
            end else if (accept_s) begin
                kill_r <= 1'b0;
            end
        end
    end

    flag_reg #(
        .FLAG_W(FLAG_W)
    ) u_flag_reg (
        .clk  (clk),
        .reset(reset),
        .we   (flag_we_s),
        .d    (ex_flag),
        .q    (flag_q)
    );

    assign ex_ready       = accept_s;
    assign mem_valid      = mem_valid_r;
    assign mem_result     = mem_result_r;
    assign mem_store_data = mem_store_data_r;
    assign mem_dest       = mem_dest_r;
    assign mem_ctrl       = mem_ctrl_r;
    assign redirect       = redirect_r;
    assign redirect_pc    = redirect_pc_r;

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their data is not available until MEM completes
    assign fwd_valid = mem_valid_r & mem_ctrl_r[CTRL_REG_WRITE] & ~mem_ctrl_r[CTRL_MEM_READ]
                     & (mem_dest_r != {REG_AW{1'b0}});
    assign fwd_dest  = mem_dest_r;
    assign fwd_data  = mem_result_r;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [2:0]  ex_flag;
    logic        ex_flag_we;
    logic        ex_branch;
    logic        ex_is_branch;
    logic [31:0] ex_target;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic [3:0]  ex_ctrl;
    logic        mem_stall;
    logic        flush;
    logic        ex_ready;
    logic        mem_valid;
    logic [31:0] mem_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_dest;
    logic [3:0]  mem_ctrl;
    logic [2:0]  flag_q;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
`endif

    int checks;
    int failures;

    typedef struct {
        logic        v;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic [2:0]  flag;
        logic        rd;
        logic [31:0] rpc;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];

    ex_mem_reg dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_flag       (ex_flag),
        .ex_flag_we    (ex_flag_we),
        .ex_branch     (ex_branch),
        .ex_is_branch  (ex_is_branch),
        .ex_target     (ex_target),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_ctrl       (ex_ctrl),
        .mem_stall     (mem_stall),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .mem_valid     (mem_valid),
        .mem_result    (mem_result),
        .mem_store_data(mem_store_data),
        .mem_dest      (mem_dest),
        .mem_ctrl      (mem_ctrl),
        .flag_q        (flag_q),
        .redirect      (redirect),
`ifdef EX_MEM_FWD_EN
        .redirect_pc   (redirect_pc),
        .fwd_valid     (fwd_valid),
        .fwd_dest      (fwd_dest),
        .fwd_data      (fwd_data)
`else
        .redirect_pc   (redirect_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [3:0] ctrl, input logic [31:0] res,
                                input logic [2:0] flag, input logic rd, input logic [31:0] rpc,
                                input bit chk_data);
        exp_t e;
        e.v = v; e.ctrl = ctrl; e.res = res; e.flag = flag;
        e.rd = rd; e.rpc = rpc; e.chk_data = chk_data;
        return e;
    endfunction

    // Monitor: registered outputs are presented once per cycle; compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mem_valid", {31'd0, mem_valid}, {31'd0, e.v});
            chk("mem_ctrl", {28'd0, mem_ctrl}, {28'd0, e.ctrl});
            chk("flag_q", {29'd0, flag_q}, {29'd0, e.flag});
            chk("redirect", {31'd0, redirect}, {31'd0, e.rd});
            chk("redirect_pc", redirect_pc, e.rpc);
            if (e.chk_data) begin
                chk("mem_result", mem_result, e.res);
                chk("mem_store_data", mem_store_data, ~e.res);
                chk("mem_dest", {27'd0, mem_dest}, {27'd0, e.res[4:0]});
            end
        end
    end

    // One EX cycle; dest and store data are derived from the result so the
    // scoreboard can check them without extra columns.
    task automatic cyc(input logic v, input logic [31:0] res, input logic [3:0] ctrl,
                       input logic [2:0] flg, input logic fwe, input logic br,
                       input logic [31:0] tgt, input logic stall, input logic fl, input exp_t e);
        ex_valid      = v;
        ex_result     = res;
        ex_store_data = ~res;
        ex_dest       = res[4:0];
        ex_ctrl       = ctrl;
        ex_flag       = flg;
        ex_flag_we    = fwe;
        ex_is_branch  = br;
        ex_branch     = br;
        ex_target     = tgt;
        mem_stall     = stall;
        flush         = fl;
        #1;
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, ~stall});
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        cyc_init();
        #12;
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_ctrl", {28'd0, mem_ctrl}, 32'd0);
        chk("rst_flag_q", {29'd0, flag_q}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic load
        cyc(1'b1, 32'h0000_00FF, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b1000, 32'hFF, 3'd0, 1'b0, 32'h0, 1'b1));
        // Stall holds 5 while 9 waits in EX
        cyc(1'b1, 32'h0000_0005, 4'b1100, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b1100, 32'h5, 3'd0, 1'b0, 32'h0, 1'b1));
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h9, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, mk(1'b1, 4'b1100, 32'h5, 3'd0, 1'b0, 32'h0, 1'b1));
        cyc(1'b1, 32'h9, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b1000, 32'h9, 3'd0, 1'b0, 32'h0, 1'b1));
        // Flush during stall, released two cycles later -> one bubble
        cyc(1'b1, 32'h11, 4'b0010, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, mk(1'b1, 4'b1000, 32'h9, 3'd0, 1'b0, 32'h0, 1'b1));
        cyc(1'b1, 32'h11, 4'b0010, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, mk(1'b1, 4'b1000, 32'h9, 3'd0, 1'b0, 32'h0, 1'b1));
        cyc(1'b1, 32'h22, 4'b0010, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 4'b0000, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0));
        cyc(1'b1, 32'h33, 4'b0110, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b0110, 32'h33, 3'd0, 1'b0, 32'h0, 1'b1));
        // Taken branch -> one-cycle redirect, next slot bubbled
        cyc(1'b1, 32'h44, 4'b0000, 3'd0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, mk(1'b1, 4'b0000, 32'h44, 3'd0, 1'b1, 32'h40, 1'b1));
        cyc(1'b1, 32'h55, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 4'b0000, 32'h0, 3'd0, 1'b0, 32'h40, 1'b0));
        cyc(1'b1, 32'h66, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b1000, 32'h66, 3'd0, 1'b0, 32'h40, 1'b1));
        // Branch followed by stall: no re-pulse, wrong-path kill survives the stall
        cyc(1'b1, 32'h77, 4'b0000, 3'd0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, mk(1'b1, 4'b0000, 32'h77, 3'd0, 1'b1, 32'h80, 1'b1));
        cyc(1'b1, 32'h88, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, mk(1'b1, 4'b0000, 32'h77, 3'd0, 1'b0, 32'h80, 1'b1));
        cyc(1'b1, 32'h88, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 4'b0000, 32'h0, 3'd0, 1'b0, 32'h80, 1'b0));
        cyc(1'b1, 32'h99, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b1000, 32'h99, 3'd0, 1'b0, 32'h80, 1'b1));
        // Flag register
        cyc(1'b1, 32'hA0, 4'b0000, 3'b101, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b0000, 32'hA0, 3'b101, 1'b0, 32'h80, 1'b1));
        cyc(1'b1, 32'hA4, 4'b0000, 3'b011, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b0000, 32'hA4, 3'b101, 1'b0, 32'h80, 1'b1));
        cyc(1'b1, 32'hB0, 4'b1000, 3'b011, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, mk(1'b0, 4'b0000, 32'h0, 3'b101, 1'b0, 32'h80, 1'b0));
        // Flag write and branch together, then killed slot must not write the flag
        cyc(1'b1, 32'hC4, 4'b0000, 3'b010, 1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, mk(1'b1, 4'b0000, 32'hC4, 3'b010, 1'b1, 32'hC0, 1'b1));
        cyc(1'b1, 32'hC8, 4'b1000, 3'b111, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 4'b0000, 32'h0, 3'b010, 1'b0, 32'hC0, 1'b0));
        // Invalid EX instruction: ctrl forced 0, flag not written
        cyc(1'b0, 32'hD0, 4'b1111, 3'b111, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 4'b0000, 32'hD0, 3'b010, 1'b0, 32'hC0, 1'b1));
        // Enter FLUSH_PEND with mem_valid=1, then reset asynchronously
        cyc(1'b1, 32'hE0, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b1000, 32'hE0, 3'b010, 1'b0, 32'hC0, 1'b1));
        cyc(1'b1, 32'hE4, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, mk(1'b1, 4'b1000, 32'hE0, 3'b010, 1'b0, 32'hC0, 1'b1));
        flush = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("arst_mem_ctrl", {28'd0, mem_ctrl}, 32'd0);
        chk("arst_mem_result", mem_result, 32'd0);
        chk("arst_flag_q", {29'd0, flag_q}, 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        // FSM back in RUN: a clean instruction loads normally
        cyc(1'b1, 32'hF0, 4'b1000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b1000, 32'hF0, 3'd0, 1'b0, 32'h0, 1'b1));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #6;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic cyc_init();
        ex_valid = 1'b0; ex_result = 32'h0; ex_store_data = 32'h0; ex_dest = 5'd0;
        ex_ctrl = 4'b0000; ex_flag = 3'd0; ex_flag_we = 1'b0; ex_is_branch = 1'b0;
        ex_branch = 1'b0; ex_target = 32'h0; mem_stall = 1'b0; flush = 1'b0;
    endtask

endmodule
